mrtu_tx: RTL and testbench

- Modbus RTU frame transmitter, the send-side counterpart of the receive-path CRC checker.
- Accepts frame payload bytes (address, function, data) from the protocol engine and forwards them to the UART transmitter.
- Computes Modbus CRC-16 on the fly and appends it, low byte first.
- Enforces a minimum inter-frame silent interval before accepting the next frame.

---
 rtl/mrtu_tx.sv | 142 ++++++++++++++
 tb/tb_mrtu_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrtu_tx.sv
// mrtu_tx: Modbus RTU frame transmitter.
//
// Forwards payload bytes (address, function, data) to a UART transmitter. It
// computes the Modbus CRC-16 (reflected poly 0xA001, init 0xFFFF) as the bytes
// pass through and appends it low byte first. After the last CRC byte leaves,
// it enforces a silent gap of GAP_CYCLES clocks before it accepts a new frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   in_data    payload byte
//   in_valid   in_data valid
//   in_last    in_data is the final payload byte of the frame
//   in_ready   byte accepted this cycle (combinational)
//   out_data   byte to the UART TX (registered)
//   out_valid  out_data valid (registered)
//   out_ready  UART TX accepts out_data this cycle
//   busy       frame in progress or gap running
//   frame_done one-cycle pulse when the gap expires
module mrtu_tx #(
    parameter int unsigned GAP_CYCLES = 3500,
    parameter int unsigned GAPW       = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StData  = 3'd1;
    localparam logic [2:0] StCrcLo = 3'd2;
    localparam logic [2:0] StCrcHi = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;

    localparam logic [GAPW-1:0] GapLast = GAPW'(GAP_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic [15:0]     crc_q, crc_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic [GAPW-1:0] cnt_q, cnt_d;

    logic out_free;
    logic in_accept;
    logic gap_end;

    // One full byte of the reflected CRC-16 update.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // The output register can take a new byte when empty or being drained.
    assign out_free  = !valid_q || out_ready;
    // Gated by reset so the source never sees ready while reset is held.
    assign in_ready  = reset && ((state_q == StIdle) || (state_q == StData)) && out_free;
    assign in_accept = in_valid && in_ready;
    // The gap only counts once the high CRC byte has left the output register.
    assign gap_end   = (state_q == StGap) && !valid_q && (cnt_q == GapLast);

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = gap_end;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        data_d  = data_q;
        valid_d = valid_q && !out_ready;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle, StData: begin
                if (in_accept) begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                    crc_d   = crc_byte(crc_q, in_data);
                    state_d = in_last ? StCrcLo : StData;
                end
            end
            StCrcLo: begin
                if (out_free) begin
                    data_d  = crc_q[7:0];
                    valid_d = 1'b1;
                    state_d = StCrcHi;
                end
            end
            StCrcHi: begin
                if (out_free) begin
                    data_d  = crc_q[15:8];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_end) begin
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (!valid_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                crc_d   = 16'hFFFF;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            crc_q   <= 16'hFFFF;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mrtu_tx.sv
// tb_mrtu_tx: directed and randomized frames against a CRC reference model.
module tb_mrtu_tx;

    localparam int unsigned GapCycles = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    mrtu_tx #(
        .GAP_CYCLES(GapCycles),
        .GAPW      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: whole-frame fold over the byte list.
    function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[k]) begin
            c = c ^ {8'h00, q[k]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Output monitor: every accepted byte, cycle stamps, frame_done pulses.
    logic [7:0] got[$];
    int cyc = 0;
    int last_acc_cyc = 0;
    int done_cnt = 0;
    int done_seen = 0;

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) begin
            got.push_back(out_data);
            last_acc_cyc = cyc;
        end
        if (reset && frame_done) done_cnt++;
        cyc++;
    end

    // Sink: 0 = always ready, 1 = random ready, 2 = stall each byte 5 cycles.
    int sink_mode = 0;
    int stall = 0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        case (sink_mode)
            0: begin out_ready = 1'b1; stall = 0; end
            1: begin out_ready = 1'($urandom_range(0, 1)); stall = 0; end
            default: begin
                if (out_valid && stall < 5) begin
                    if (stall > 0) begin
                        chk("bp_data_stable", {24'h0, out_data}, {24'h0, held});
                        chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
                    end
                    held = out_data;
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                    stall = 0;
                end
            end
        endcase
    end

    task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last = 1'($urandom_range(0, 1));
                in_data = 8'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("in_ready_timeout", 32'(n < 200), 32'h1);
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] q[$], input bit gaps);
        foreach (q[k]) send_byte(q[k], k == q.size() - 1, gaps);
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_frame(input logic [7:0] exp[$], input string tag);
        int n;
        n = 0;
        while (done_cnt == done_seen && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_timeout"}, 32'(n < 4000), 32'h1);
        chk({tag, "_done_once"}, 32'(done_cnt), 32'(done_seen + 1));
        done_seen = done_cnt;
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[k]) begin
            if (k < got.size()) chk($sformatf("%s_byte%0d", tag, k), {24'h0, got[k]},
                                    {24'h0, exp[k]});
        end
        got.delete();
    endtask

    function automatic void with_crc(input logic [7:0] q[$], output logic [7:0] e[$]);
        logic [15:0] c;
        c = model_crc(q);
        e = q;
        e.push_back(c[7:0]);
        e.push_back(c[15:8]);
    endfunction

    initial begin
        logic [7:0] pl[$];
        logic [7:0] ex[$];
        int n;
        int early;

        // Reset state.
        #12;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'h0, in_ready}, 32'h1);

        // Known vectors.
        sink_mode = 0;
        pl = '{8'hFF, 8'hFF, 8'hFF};
        ex = '{8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h40};
        send_frame(pl, 0);
        wait_frame(ex, "ffx3");

        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        ex = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h9B, 8'hC1};
        send_frame(pl, 0);
        wait_frame(ex, "deadbeef");

        pl = '{8'h00};
        ex = '{8'h00, 8'hBF, 8'h40};
        send_frame(pl, 0);
        wait_frame(ex, "single00");

        pl = '{8'h00, 8'h00};
        ex = '{8'h00, 8'h00, 8'h01, 8'hB0};
        send_frame(pl, 0);
        wait_frame(ex, "reload0000");

        // Back-pressure on every byte, including both CRC bytes.
        sink_mode = 2;
        pl = '{8'h11, 8'h22, 8'h33};
        with_crc(pl, ex);
        send_frame(pl, 0);
        wait_frame(ex, "backpressure");

        // Gap timing with an always-ready sink.
        sink_mode = 0;
        pl = '{8'h12, 8'h34};
        with_crc(pl, ex);
        send_frame(pl, 0);
        n = 0;
        early = 0;
        while (!frame_done && n < 100) begin
            if (in_ready) early++;
            @(negedge clk);
            n++;
        end
        chk("gap_pulse_seen", 32'(n < 100), 32'h1);
        chk("gap_no_early_ready", 32'(early), 32'h0);
        chk("gap_ready_at_done", {31'h0, in_ready}, 32'h0);
        chk("gap_length", 32'(cyc - last_acc_cyc), 32'(GapCycles));
        @(negedge clk);
        chk("gap_after_ready", {31'h0, in_ready}, 32'h1);
        chk("gap_after_busy", {31'h0, busy}, 32'h0);
        chk("gap_after_done_low", {31'h0, frame_done}, 32'h0);
        wait_frame(ex, "gapframe");

        // Asynchronous reset mid-frame.
        sink_mode = 2;
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h55, 1'b0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        sink_mode = 0;
        got.delete();
        repeat (20) @(negedge clk);
        chk("midrst_no_crc", 32'(got.size()), 32'h0);
        chk("midrst_no_done", 32'(done_cnt), 32'(done_seen));
        pl = '{8'hFF};
        ex = '{8'hFF, 8'hFF, 8'h00};
        send_frame(pl, 0);
        wait_frame(ex, "after_reset");

        // Randomized frames, sink behaviour and source gaps.
        for (int f = 0; f < 8; f++) begin
            pl.delete();
            repeat ($urandom_range(1, 8)) pl.push_back(8'($urandom));
            with_crc(pl, ex);
            sink_mode = $urandom_range(0, 2);
            send_frame(pl, 1'($urandom_range(0, 1)));
            wait_frame(ex, $sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
